// File: rtl/drive_cmd_ctrl_pkg.sv
// Shared types, source codes, neutral defaults and the speed slew helper
// for the drive command sequencer.
package drive_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    FAILSAFE = 2'd2,
    ESTOP    = 2'd3
  } drv_state_t;

  typedef struct packed {
    logic [7:0] dir;
    logic [7:0] spd;
  } drv_cmd_t;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_A    = 2'd1;
  localparam logic [1:0] SRC_B    = 2'd2;

  localparam logic [7:0] NEUTRAL_SPD_DEF = 8'd0;
  localparam logic [7:0] NEUTRAL_DIR_DEF = 8'd128;

  // One slew step toward target; the distance is taken in 9 bits so the
  // step can never carry past 255 or borrow past 0.
  function automatic logic [7:0] slew_step(input logic [7:0] cur,
                                           input logic [7:0] target,
                                           input logic [7:0] step);
    logic [8:0] diff;
    logic [7:0] res;
    diff = 9'd0;
    res  = cur;
    if (target > cur) begin
      diff = {1'b0, target} - {1'b0, cur};
      if (diff <= {1'b0, step}) begin
        res = target;
      end else begin
        res = cur + step;
      end
    end else if (target < cur) begin
      diff = {1'b0, cur} - {1'b0, target};
      if (diff <= {1'b0, step}) begin
        res = target;
      end else begin
        res = cur - step;
      end
    end else begin
      res = cur;
    end
    return res;
  endfunction

endpackage

// File: rtl/drive_cmd_ctrl_spd_ramp.sv
// Speed slew limiter: free-running tick divider plus a bounded step toward
// the target on every tick; force_neutral bypasses the ramp entirely.
module spd_ramp
  import drive_pkg::*;
#(
  parameter int         RAMP_DIV    = 1000,
  parameter int         STEP        = 4,
  parameter logic [7:0] NEUTRAL_SPD = NEUTRAL_SPD_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] target,
  input  logic       force_neutral,
  output logic [7:0] cur
);

  localparam int             CNT_W   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAMP_DIV - 1);
  localparam logic [7:0]     STEP_B  = 8'(STEP);

  logic [CNT_W-1:0] tick_cnt_r;
  logic             tick_s;
  logic [7:0]       cur_r;

  assign tick_s = (tick_cnt_r == CNT_MAX);
  assign cur    = cur_r;

  // Tick divider: wraps at RAMP_DIV-1 and pulses tick_s on the wrap cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_r <= '0;
    end else if (tick_s) begin
      tick_cnt_r <= '0;
    end else begin
      tick_cnt_r <= tick_cnt_r + CNT_W'(1);
    end
  end

  // Current speed: immediate neutral on force, otherwise one slew step per tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_r <= NEUTRAL_SPD;
    end else if (force_neutral) begin
      cur_r <= NEUTRAL_SPD;
    end else if (tick_s) begin
      cur_r <= slew_step(cur_r, target, STEP_B);
    end else begin
      cur_r <= cur_r;
    end
  end

endmodule

// File: rtl/drive_cmd_ctrl.sv
// Drive command sequencer: two-requester arbitration (B has priority),
// command watchdog with failsafe, emergency stop, and the PWM data word.
module drive_cmd_ctrl
  import drive_pkg::*;
#(
  parameter int         RAMP_DIV    = 1000,
  parameter int         STEP        = 4,
  parameter int         WDOG_CYCLES = 100000,
  parameter logic [7:0] NEUTRAL_SPD = NEUTRAL_SPD_DEF,
  parameter logic [7:0] NEUTRAL_DIR = NEUTRAL_DIR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [15:0] a_cmd,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [15:0] b_cmd,
  output logic        b_ready,
  input  logic        estop,
  output logic [15:0] data_out,
  output logic [1:0]  source,
  output logic        fault
);

  localparam int              WD_W   = $clog2(WDOG_CYCLES);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_CYCLES - 1);

  drv_state_t      state_r, state_nxt_s;
  logic [7:0]      dir_tgt_r, dir_tgt_nxt_s;
  logic [7:0]      spd_tgt_r, spd_tgt_nxt_s;
  logic [7:0]      dir_out_r, dir_out_nxt_s;
  logic [1:0]      source_r, source_nxt_s;
  logic            fault_r;
  logic [WD_W-1:0] wdog_r, wdog_nxt_s;
  logic            b_ready_s, a_ready_s, acc_a_s, acc_b_s, acc_s, expire_s;
  logic            force_neutral_s;
  logic [7:0]      spd_cur_s;
  drv_cmd_t        acc_cmd_s;

  // Readiness never looks at a_valid, so A cannot create a combinational loop.
  assign b_ready_s       = (state_r != ESTOP) & ~estop;
  assign a_ready_s       = b_ready_s & ~b_valid;
  assign acc_b_s         = b_valid & b_ready_s;
  assign acc_a_s         = a_valid & a_ready_s;
  assign acc_s           = acc_a_s | acc_b_s;
  assign acc_cmd_s       = acc_b_s ? drv_cmd_t'(b_cmd) : drv_cmd_t'(a_cmd);
  assign expire_s        = (state_r == RUN) && (wdog_r == WD_MAX);
  assign force_neutral_s = estop | (state_r == ESTOP);

  assign a_ready  = a_ready_s;
  assign b_ready  = b_ready_s;
  assign data_out = {dir_out_r, spd_cur_s};
  assign source   = source_r;
  assign fault    = fault_r;

  spd_ramp #(
    .RAMP_DIV    (RAMP_DIV),
    .STEP        (STEP),
    .NEUTRAL_SPD (NEUTRAL_SPD)
  ) u_spd_ramp (
    .clk           (clk),
    .rst           (rst),
    .target        (spd_tgt_r),
    .force_neutral (force_neutral_s),
    .cur           (spd_cur_s)
  );

  // Next-state logic: estop dominates, then accept, then watchdog expiry.
  always_comb begin
    state_nxt_s   = state_r;
    dir_tgt_nxt_s = dir_tgt_r;
    spd_tgt_nxt_s = spd_tgt_r;
    dir_out_nxt_s = dir_out_r;
    source_nxt_s  = source_r;
    wdog_nxt_s    = wdog_r;
    if (estop) begin
      state_nxt_s   = ESTOP;
      spd_tgt_nxt_s = NEUTRAL_SPD;
    end else begin
      case (state_r)
        ESTOP: begin
          state_nxt_s   = IDLE;
          dir_tgt_nxt_s = NEUTRAL_DIR;
          spd_tgt_nxt_s = NEUTRAL_SPD;
          dir_out_nxt_s = NEUTRAL_DIR;
          source_nxt_s  = SRC_NONE;
          wdog_nxt_s    = '0;
        end
        IDLE, RUN, FAILSAFE: begin
          dir_out_nxt_s = dir_tgt_r;
          if (acc_s) begin
            state_nxt_s   = RUN;
            dir_tgt_nxt_s = acc_cmd_s.dir;
            spd_tgt_nxt_s = acc_cmd_s.spd;
            source_nxt_s  = acc_b_s ? SRC_B : SRC_A;
            wdog_nxt_s    = '0;
          end else if (expire_s) begin
            state_nxt_s   = FAILSAFE;
            dir_tgt_nxt_s = NEUTRAL_DIR;
            spd_tgt_nxt_s = NEUTRAL_SPD;
          end else if (state_r == RUN) begin
            wdog_nxt_s = wdog_r + WD_W'(1);
          end else begin
            wdog_nxt_s = '0;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      dir_tgt_r <= NEUTRAL_DIR;
      spd_tgt_r <= NEUTRAL_SPD;
      dir_out_r <= NEUTRAL_DIR;
      source_r  <= SRC_NONE;
      fault_r   <= 1'b0;
      wdog_r    <= '0;
    end else begin
      state_r   <= state_nxt_s;
      dir_tgt_r <= dir_tgt_nxt_s;
      spd_tgt_r <= spd_tgt_nxt_s;
      dir_out_r <= dir_out_nxt_s;
      source_r  <= source_nxt_s;
      fault_r   <= (state_nxt_s == FAILSAFE);
      wdog_r    <= wdog_nxt_s;
    end
  end

endmodule

// File: tb/tb_drive_cmd_ctrl.sv
// Self-checking bench for drive_cmd_ctrl; speed steps are checked against
// a queue of expected values filled when each command is issued.
module tb_drive_cmd_ctrl;

  localparam int RAMP_DIV = 4;
  localparam int STEP     = 4;
  localparam int WDOG     = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0;
  logic        b_valid = 1'b0;
  logic        estop = 1'b0;
  logic [15:0] a_cmd = 16'h0000;
  logic [15:0] b_cmd = 16'h0000;
  logic        a_ready, b_ready, fault;
  logic [15:0] data_out;
  logic [1:0]  source;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  drive_cmd_ctrl #(
    .RAMP_DIV    (RAMP_DIV),
    .STEP        (STEP),
    .WDOG_CYCLES (WDOG)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a_valid  (a_valid),
    .a_cmd    (a_cmd),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_cmd    (b_cmd),
    .b_ready  (b_ready),
    .estop    (estop),
    .data_out (data_out),
    .source   (source),
    .fault    (fault)
  );

  // One-cycle handshake; returns on the falling edge after the accepting edge.
  task automatic send(input bit use_b, input logic [15:0] cmd);
    @(negedge clk);
    if (use_b) begin
      b_valid = 1'b1;
      b_cmd   = cmd;
    end else begin
      a_valid = 1'b1;
      a_cmd   = cmd;
    end
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic wait_spd(input string name, input logic [7:0] val, input int budget);
    int c;
    c = 0;
    while (data_out[7:0] !== val && c < budget) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (data_out[7:0] !== val) begin
      bad++;
      $display("FAIL %s: spd=%0d expected=%0d (timeout)", name, data_out[7:0], val);
    end
  endtask

  // Pops one expected value per observed speed change, checks step spacing,
  // then requires the speed to hold still for 'hold' cycles.
  task automatic run_sb(input string name, input logic [7:0] prev_in, input int budget, input int hold);
    logic [7:0] prev, e;
    int last;
    bit armed, held_ok;
    prev = prev_in;
    armed = 1'b0;
    last = 0;
    for (int c = 1; c <= budget && exp_q.size() > 0; c++) begin
      if (c > 1 || data_out[7:0] === prev) @(negedge clk);
      if (data_out[7:0] !== prev) begin
        e = exp_q.pop_front();
        total++;
        if (data_out[7:0] !== e) begin
          bad++;
          $display("FAIL %s step: spd=%0d expected=%0d", name, data_out[7:0], e);
        end
        if (armed) begin
          total++;
          if ((c - last) != RAMP_DIV) begin
            bad++;
            $display("FAIL %s gap: cycles=%0d expected=%0d", name, c - last, RAMP_DIV);
          end
        end
        armed = 1'b1;
        last = c;
        prev = data_out[7:0];
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s timeout: %0d steps missing, next expected=%0d", name, exp_q.size(), exp_q[0]);
      exp_q.delete();
    end
    if (hold > 0) begin
      held_ok = 1'b1;
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        if (data_out[7:0] !== prev) held_ok = 1'b0;
      end
      total++;
      if (!held_ok) begin
        bad++;
        $display("FAIL %s hold: spd=%0d expected=%0d", name, data_out[7:0], prev);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (data_out !== 16'h8000 || source !== 2'd0 || fault !== 1'b0) begin
      bad++;
      $display("FAIL reset_vals: data_out=%h source=%0d fault=%b expected 8000/0/0", data_out, source, fault);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1 || data_out !== 16'h8000) begin
      bad++;
      $display("FAIL reset_idle: a_ready=%b b_ready=%b data_out=%h expected 1/1/8000", a_ready, b_ready, data_out);
    end
  endtask

  task automatic test_single_a();
    for (int v = 4; v <= 16; v += 4) exp_q.push_back(8'(v));
    @(negedge clk);
    a_valid = 1'b1;
    a_cmd   = 16'h4010;
    #1;
    total++;
    if (a_ready !== 1'b1) begin
      bad++;
      $display("FAIL t1_a_ready: got=%b expected=1", a_ready);
    end
    @(negedge clk);
    a_valid = 1'b0;
    total++;
    if (source !== 2'd1) begin
      bad++;
      $display("FAIL t1_source: got=%0d expected=1", source);
    end
    total++;
    if (data_out[15:8] !== 8'd128) begin
      bad++;
      $display("FAIL t1_dir_lat: got=%h expected=80", data_out[15:8]);
    end
    @(negedge clk);
    total++;
    if (data_out[15:8] !== 8'h40) begin
      bad++;
      $display("FAIL t1_dir: got=%h expected=40", data_out[15:8]);
    end
    run_sb("t1_ramp", 8'd0, 40, 8);
    total++;
    if (data_out !== 16'h4010) begin
      bad++;
      $display("FAIL t1_final: got=%h expected=4010", data_out);
    end
  endtask

  task automatic test_priority();
    exp_q.push_back(8'd12);
    exp_q.push_back(8'd8);
    @(negedge clk);
    a_valid = 1'b1;
    a_cmd   = 16'h20FF;
    b_valid = 1'b1;
    b_cmd   = 16'h8008;
    #1;
    total++;
    if (a_ready !== 1'b0 || b_ready !== 1'b1) begin
      bad++;
      $display("FAIL t2_ready: a_ready=%b b_ready=%b expected 0/1", a_ready, b_ready);
    end
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
    total++;
    if (source !== 2'd2) begin
      bad++;
      $display("FAIL t2_source: got=%0d expected=2", source);
    end
    run_sb("t2_ramp", 8'd16, 40, 6);
    total++;
    if (data_out !== 16'h8008 || a_ready !== 1'b1) begin
      bad++;
      $display("FAIL t2_final: data_out=%h a_ready=%b expected 8008/1", data_out, a_ready);
    end
  endtask

  task automatic test_no_overshoot();
    @(negedge clk);
    b_valid = 1'b1;
    b_cmd   = 16'h80C8;
    wait_spd("t3_reach200", 8'd200, 300);
    b_valid = 1'b0;
    exp_q.push_back(8'd198);
    send(1'b1, 16'h80C6);
    run_sb("t3_down198", 8'd200, 12, 4);
    for (int v = 202; v <= 250; v += 4) exp_q.push_back(8'(v));
    exp_q.push_back(8'd254);
    exp_q.push_back(8'd255);
    @(negedge clk);
    b_valid = 1'b1;
    b_cmd   = 16'h80FF;
    run_sb("t3_up255", 8'd198, 100, 8);
    b_valid = 1'b0;
    total++;
    if (data_out !== 16'h80FF) begin
      bad++;
      $display("FAIL t3_final: got=%h expected=80ff", data_out);
    end
  endtask

  task automatic test_watchdog();
    send(1'b0, 16'h4010);
    repeat (WDOG - 1) @(negedge clk);
    total++;
    if (fault !== 1'b0) begin
      bad++;
      $display("FAIL t4_early: fault=%b expected=0", fault);
    end
    @(negedge clk);
    total++;
    if (fault !== 1'b1) begin
      bad++;
      $display("FAIL t4_expire: fault=%b expected=1", fault);
    end
    @(negedge clk);
    total++;
    if (data_out[15:8] !== 8'd128) begin
      bad++;
      $display("FAIL t4_dir: got=%h expected=80", data_out[15:8]);
    end
    wait_spd("t4_ramp0", 8'd0, 400);
    total++;
    if (data_out !== 16'h8000 || fault !== 1'b1) begin
      bad++;
      $display("FAIL t4_failsafe: data_out=%h fault=%b expected 8000/1", data_out, fault);
    end
    send(1'b0, 16'h2030);
    total++;
    if (fault !== 1'b0 || source !== 2'd1) begin
      bad++;
      $display("FAIL t4_recover: fault=%b source=%0d expected 0/1", fault, source);
    end
    @(negedge clk);
    total++;
    if (data_out[15:8] !== 8'h20) begin
      bad++;
      $display("FAIL t4_run_dir: got=%h expected=20", data_out[15:8]);
    end
    // Land the next accept on the cycle the watchdog would otherwise expire.
    repeat (WDOG - 2) @(negedge clk);
    a_valid = 1'b1;
    a_cmd   = 16'h2064;
    @(negedge clk);
    a_valid = 1'b0;
    total++;
    if (fault !== 1'b0) begin
      bad++;
      $display("FAIL t4_race: fault=%b expected=0", fault);
    end
    @(negedge clk);
    total++;
    if (fault !== 1'b0) begin
      bad++;
      $display("FAIL t4_race_after: fault=%b expected=0", fault);
    end
  endtask

  task automatic test_estop();
    @(negedge clk);
    a_valid = 1'b1;
    a_cmd   = 16'h2064;
    wait_spd("t5_reach60", 8'd60, 200);
    estop = 1'b1;
    a_cmd = 16'h10F0;
    #1;
    total++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      bad++;
      $display("FAIL t5_ready: a_ready=%b b_ready=%b expected 0/0", a_ready, b_ready);
    end
    @(negedge clk);
    total++;
    if (data_out !== 16'h2000) begin
      bad++;
      $display("FAIL t5_stop: data_out=%h expected=2000", data_out);
    end
    estop   = 1'b0;
    a_valid = 1'b0;
    @(negedge clk);
    total++;
    if (data_out !== 16'h8000 || source !== 2'd0 || fault !== 1'b0 || a_ready !== 1'b1) begin
      bad++;
      $display("FAIL t5_idle: data_out=%h source=%0d fault=%b a_ready=%b expected 8000/0/0/1",
               data_out, source, fault, a_ready);
    end
    repeat (10) @(negedge clk);
    total++;
    if (data_out !== 16'h8000 || source !== 2'd0) begin
      bad++;
      $display("FAIL t5_hold: data_out=%h source=%0d expected 8000/0", data_out, source);
    end
  endtask

  task automatic test_async_reset();
    send(1'b0, 16'h4080);
    repeat (8) @(negedge clk);
    total++;
    if (data_out[7:0] === 8'd0 || source !== 2'd1) begin
      bad++;
      $display("FAIL t6_midramp: spd=%0d source=%0d expected nonzero/1", data_out[7:0], source);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (data_out !== 16'h8000 || source !== 2'd0 || fault !== 1'b0) begin
      bad++;
      $display("FAIL t6_async: data_out=%h source=%0d fault=%b expected 8000/0/0", data_out, source, fault);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    total++;
    if (data_out !== 16'h8000 || source !== 2'd0) begin
      bad++;
      $display("FAIL t6_no_resume: data_out=%h source=%0d expected 8000/0", data_out, source);
    end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_priority();
    test_no_overshoot();
    test_watchdog();
    test_estop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
